// File: rtl/bitserial_addsub_seq_if.sv
// Start/done request bus between a requester and the bit-serial add/sub sequencer.
interface bitserial_addsub_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;

  modport master (output start, op, a, b, input busy, done, result, cout);
  modport slave  (input start, op, a, b, output busy, done, result, cout);
endinterface

// File: rtl/bitserial_addsub_seq.sv
// Bit-serial WIDTH-bit add/subtract sequencer: one shared 1-bit cell, LSB first,
// one bit per clock, result published through a held output register at DONE.
module bitserial_addsub_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  input  logic i_sub,
  output logic o_s,
  output logic o_cout
);
  logic w_h1, w_g1, w_g2;

  // Two half stages; subtract only inverts the minuend term in each generate.
  assign w_h1   = i_a ^ i_b;
  assign w_g1   = (i_sub ? ~i_a : i_a) & i_b;
  assign o_s    = w_h1 ^ i_cin;
  assign w_g2   = (i_sub ? ~w_h1 : w_h1) & i_cin;
  assign o_cout = w_g1 | w_g2;
endmodule

module bitserial_addsub_seq #(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  bitserial_addsub_seq_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_nxt;
  logic [WIDTH-1:0] r_a, r_b, r_acc, r_result;
  logic [CW-1:0]    r_cnt;
  logic             r_op, r_cy, r_cout;
  logic             w_s, w_c, w_busy, w_done;

  bitserial_addsub_cell u_cell (
    .i_a    (r_a[0]),
    .i_b    (r_b[0]),
    .i_cin  (r_cy),
    .i_sub  (r_op),
    .o_s    (w_s),
    .o_cout (w_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt  = r_state;
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_IDLE: if (bus.start) w_nxt = S_RUN;
      S_RUN: begin
        w_busy = 1'b1;
        if (r_cnt == LAST) w_nxt = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_nxt  = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= 1'b0;
      r_cy     <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_a   <= bus.a;
          r_b   <= bus.b;
          r_op  <= bus.op;
          r_cy  <= 1'b0;
          r_cnt <= '0;
        end
        S_RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_acc <= {w_s, r_acc[WIDTH-1:1]};
          r_cy  <= w_c;
          r_cnt <= r_cnt + CW'(1);
          // Output register only changes on the RUN->DONE edge, so RUN shows the old result.
          if (r_cnt == LAST) begin
            r_result <= {w_s, r_acc[WIDTH-1:1]};
            r_cout   <= w_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = w_busy;
  assign bus.done   = w_done;
  assign bus.result = r_result;
  assign bus.cout   = r_cout;
endmodule
